// File: rtl/barrett_red_pipe.sv
// barrett_red_pipe
//   Streaming Barrett modular reducer: y = a mod m. It accepts one operand per
//   cycle and produces the result 4 cycles after acceptance. A valid/ready
//   handshake on both sides gives full backpressure, and a tag travels in order
//   with each operand.
//
//   Pipeline
//     S1   q1 = x >> (k-1), low bits of x, tag
//     S2   q2 = q1 * mu
//     S3   r  = x - (q2 >> (k+1)) * m   (NBITS+2 bits, r < 3m)
//     S4   r, r-m and r-2m, computed in parallel
//     out  the smallest non-negative candidate is registered onto y
//
//   Ports
//     clk, rst_n                    clock, asynchronous active-low reset
//     cfg_we/cfg_m/cfg_mu/cfg_k     modulus context load, accepted only when idle
//     cfg_drop                      pulses one cycle after a rejected cfg_we
//     busy                          registered OR of all occupied stages
//     in_valid/in_ready/a/in_tag    operand stream
//     out_valid/out_ready/y/out_tag result stream
//     out_err                       operand was out of range (x >= 2^(2k))
//
//   Optional feature macro: BARRETT_RED_PIPE_RANGE_CHK_EN
//     When defined, a range comparator drives out_err. When undefined,
//     out_err is tied to 0.
module barrett_red_pipe #(
  parameter int NBITS = 128,
  parameter int TAGW  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [NBITS-1:0]       cfg_m,
  input  logic [NBITS:0]         cfg_mu,
  input  logic [$clog2(NBITS):0] cfg_k,
  output logic                   cfg_drop,
  output logic                   busy,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*NBITS-1:0]     a,
  input  logic [TAGW-1:0]        in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NBITS-1:0]       y,
  output logic [TAGW-1:0]        out_tag,
  output logic                   out_err
);
  localparam int N  = NBITS;
  localparam int KW = $clog2(NBITS) + 1;

  logic [N-1:0]  m_r;
  logic [N:0]    mu_r;
  logic [KW-1:0] k_r;

  logic stall, adv, cfg_ok;
  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = adv;
  assign cfg_ok   = cfg_we & ~busy & ~in_valid;

  logic            v1, v2, v3, v4;
  logic [TAGW-1:0] tag1, tag2, tag3, tag4;
  logic [N+1:0]    x1, x2;
  logic [N:0]      q1_r;
  logic [2*N+1:0]  q2_r;
  logic [N+1:0]    r3;
  logic [N+1:0]    c0;
  logic [N+2:0]    c1, c2;

  logic [N:0]      q1_c;
  logic [2*N+1:0]  q2_c;
  logic [N+1:0]    q3_c, r_c;
  logic [N+2:0]    d1_c, d2_c;
  logic [N-1:0]    y_c;
  logic [4:0]      v_nxt;

  // Under the x < 2^(2k) precondition, q1 fits in k+1 bits and q3 fits in
  // NBITS+2 bits, so the truncating casts drop only zero bits.
  always_comb begin
    q1_c = (N+1)'(a >> (k_r - KW'(1)));
    q2_c = {{(N+1){1'b0}}, q1_r} * {{(N+1){1'b0}}, mu_r};
    q3_c = (N+2)'(q2_r >> (k_r + KW'(1)));
    r_c  = x2 - q3_c * {2'b00, m_r};
    d1_c = {1'b0, r3} - {3'b000, m_r};
    d2_c = {1'b0, r3} - {2'b00, m_r, 1'b0};
  end

  // The top bit of each difference is its borrow, i.e. the sign.
  always_comb begin
    y_c = N'(c0);
    if (!c2[N+2])      y_c = N'(c2);
    else if (!c1[N+2]) y_c = N'(c1);
  end

  // busy is a flop that tracks the occupancy the stages will have after this
  // edge. The output register counts as a stage, so the context cannot change
  // while a result is still waiting on out_ready.
  always_comb begin
    v_nxt = {v1, v2, v3, v4, out_valid};
    if (adv) v_nxt = {in_valid, v1, v2, v3, v4};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_r      <= '0;
      mu_r     <= '0;
      k_r      <= '0;
      cfg_drop <= 1'b0;
      busy     <= 1'b0;
    end else begin
      cfg_drop <= cfg_we & ~cfg_ok;
      busy     <= |v_nxt;
      if (cfg_ok) begin
        m_r  <= cfg_m;
        mu_r <= cfg_mu;
        k_r  <= cfg_k;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; v4 <= 1'b0;
      tag1 <= '0; tag2 <= '0; tag3 <= '0; tag4 <= '0;
      x1 <= '0; x2 <= '0; q1_r <= '0; q2_r <= '0; r3 <= '0;
      c0 <= '0; c1 <= '0; c2 <= '0;
      out_valid <= 1'b0;
      out_tag   <= '0;
      y         <= '0;
    end else if (adv) begin
      v1 <= in_valid; tag1 <= in_tag; x1 <= (N+2)'(a); q1_r <= q1_c;
      v2 <= v1;       tag2 <= tag1;   x2 <= x1;         q2_r <= q2_c;
      v3 <= v2;       tag3 <= tag2;   r3 <= r_c;
      v4 <= v3;       tag4 <= tag3;   c0 <= r3; c1 <= d1_c; c2 <= d2_c;
      out_valid <= v4;
      out_tag   <= tag4;
      y         <= y_c;
    end
  end

`ifdef BARRETT_RED_PIPE_RANGE_CHK_EN
  // x >= 2^(2k) exactly when any bit survives a right shift by 2k.
  logic rng_c, e1, e2, e3, e4, err_q;
  assign rng_c = |(a >> {k_r, 1'b0});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e1 <= 1'b0; e2 <= 1'b0; e3 <= 1'b0; e4 <= 1'b0; err_q <= 1'b0;
    end else if (adv) begin
      e1 <= rng_c; e2 <= e1; e3 <= e2; e4 <= e3; err_q <= e4;
    end
  end
  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_barrett_red_pipe.sv
module tb_barrett_red_pipe;
  localparam int N  = 128;
  localparam int TW = 4;
  localparam int KW = $clog2(N) + 1;
  localparam int W2 = 2 * N;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            cfg_we = 1'b0;
  logic [N-1:0]    cfg_m = '0;
  logic [N:0]      cfg_mu = '0;
  logic [KW-1:0]   cfg_k = '0;
  logic            cfg_drop, busy;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W2-1:0]   a = '0;
  logic [TW-1:0]   in_tag = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [N-1:0]    y;
  logic [TW-1:0]   out_tag;
  logic            out_err;

  barrett_red_pipe #(.NBITS(N), .TAGW(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_m(cfg_m), .cfg_mu(cfg_mu), .cfg_k(cfg_k),
    .cfg_drop(cfg_drop), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .out_tag(out_tag),
    .out_err(out_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [N-1:0]  cur_m = '0;
  int            cur_k = 0;

  typedef struct packed {
    logic [N-1:0]  y;
    logic [TW-1:0] tag;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [W2-1:0] got, input logic [W2-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [N:0] calc_mu(input logic [N-1:0] m, input int k);
    logic [W2:0] p;
    p = (W2+1)'(1) << (2 * k);
    p = p / {{(N+1){1'b0}}, m};
    return p[N:0];
  endfunction

  function automatic logic [N-1:0] ref_mod(input logic [W2-1:0] x, input logic [N-1:0] m);
    logic [W2-1:0] r;
    r = x % {{N{1'b0}}, m};
    return r[N-1:0];
  endfunction

  function automatic logic exp_err(input logic [W2-1:0] x, input int k);
`ifdef BARRETT_RED_PIPE_RANGE_CHK_EN
    return |(x >> (2 * k));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [W2-1:0] rnd_wide();
    logic [W2-1:0] r;
    r = '0;
    for (int i = 0; i < W2 / 32; i++) r = {r[W2-33:0], 32'($urandom)};
    return r;
  endfunction

  task automatic load_cfg(input logic [N-1:0] m, input int k);
    @(negedge clk);
    chk("cfg_idle_busy", W2'(busy), W2'(0));
    cfg_we = 1'b1; cfg_m = m; cfg_k = KW'(k); cfg_mu = calc_mu(m, k);
    @(negedge clk);
    cfg_we = 1'b0;
    chk("cfg_accept_drop", W2'(cfg_drop), W2'(0));
    cur_m = m; cur_k = k;
  endtask

  task automatic single_op(input logic [W2-1:0] x, input logic [TW-1:0] t);
    logic ee;
    ee = exp_err(x, cur_k);
    @(negedge clk);
    a = x; in_tag = t; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk("op_in_ready", W2'(in_ready), W2'(1));
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("op_latency_early", W2'(out_valid), W2'(0));
      @(negedge clk);
    end
    chk("op_latency_valid", W2'(out_valid), W2'(1));
    if (!ee) chk("op_y", W2'(y), W2'(ref_mod(x, cur_m)));
    chk("op_tag", W2'(out_tag), W2'(t));
    chk("op_err", W2'(out_err), W2'(ee));
  endtask

  task automatic wait_out(input logic [N-1:0] ey, input logic [TW-1:0] et);
    int n;
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("wait_out_valid", W2'(out_valid), W2'(1));
    chk("wait_out_y", W2'(y), W2'(ey));
    chk("wait_out_tag", W2'(out_tag), W2'(et));
    @(negedge clk);
  endtask

  task automatic run_stream(input int n, input int low_pct);
    int sent, rcv, cyc;
    logic hold;
    logic [N-1:0] py;
    logic [TW-1:0] pt;
    exp_t e;
    sent = 0; rcv = 0; cyc = 0; hold = 1'b0; py = '0; pt = '0;
    sb.delete();
    @(negedge clk);
    while (rcv < n && cyc < 20 * n + 100) begin
      in_valid  = (sent < n);
      a         = rnd_wide();
      in_tag    = TW'(sent);
      out_ready = ($urandom_range(99) >= low_pct);
      #1;
      chk("in_ready_rule", W2'(in_ready), W2'(!(out_valid && !out_ready)));
      if (hold) begin
        chk("stall_valid_hold", W2'(out_valid), W2'(1));
        chk("stall_y_hold", W2'(y), W2'(py));
        chk("stall_tag_hold", W2'(out_tag), W2'(pt));
      end
      if (in_valid && in_ready) begin
        sb.push_back({ref_mod(a, cur_m), in_tag});
        sent++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("extra_result", W2'(1), W2'(0));
        end else begin
          e = sb.pop_front();
          chk("stream_y", W2'(y), W2'(e.y));
          chk("stream_tag", W2'(out_tag), W2'(e.tag));
          chk("stream_err", W2'(out_err), W2'(0));
        end
        rcv++;
      end
      hold = out_valid && !out_ready;
      py = y; pt = out_tag;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_count", W2'(rcv), W2'(n));
    chk("stream_sb_empty", W2'(sb.size()), W2'(0));
    if (low_pct == 0) chk("stream_thruput_cycles", W2'(cyc), W2'(n + 5));
  endtask

  initial begin
    logic [N-1:0] rm;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", W2'(out_valid), W2'(0));
    chk("rst_y", W2'(y), W2'(0));
    chk("rst_out_tag", W2'(out_tag), W2'(0));
    chk("rst_out_err", W2'(out_err), W2'(0));
    chk("rst_busy", W2'(busy), W2'(0));
    chk("rst_cfg_drop", W2'(cfg_drop), W2'(0));
    chk("rst_in_ready", W2'(in_ready), W2'(1));
    rst_n = 1'b1;

    load_cfg(N'(13), 4);
    single_op(W2'(255), 4'h1);
    chk("plan_255", W2'(y), W2'(8));
    single_op(W2'(168), 4'h2);
    chk("plan_168", W2'(y), W2'(12));
    single_op(W2'(169), 4'h3);
    single_op(W2'(0),   4'h4);
    single_op(W2'(256), 4'h5);
    single_op(W2'(255), 4'h6);

    // cfg_we while busy is dropped and the context stays m=13
    @(negedge clk);
    a = W2'(100); in_tag = 4'h7; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("drop_busy_high", W2'(busy), W2'(1));
    cfg_we = 1'b1; cfg_m = N'(97); cfg_k = KW'(7); cfg_mu = calc_mu(N'(97), 7);
    @(negedge clk);
    cfg_we = 1'b0;
    chk("drop_busy_pulse", W2'(cfg_drop), W2'(1));
    @(negedge clk);
    chk("drop_pulse_end", W2'(cfg_drop), W2'(0));
    wait_out(N'(9), 4'h7);

    // cfg_we together with in_valid is dropped as well
    @(negedge clk);
    cfg_we = 1'b1; a = W2'(50); in_tag = 4'h8; in_valid = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; in_valid = 1'b0;
    chk("drop_inval_pulse", W2'(cfg_drop), W2'(1));
    wait_out(N'(11), 4'h8);

    load_cfg(N'(97), 7);
    single_op(W2'(9408), 4'h9);
    chk("plan_9408", W2'(y), W2'(96));

    rm = {1'b1, (N-2)'(rnd_wide()), 1'b1};
    load_cfg(rm, N);
    run_stream(1000, 0);
    run_stream(1000, 30);

    // reset with three entries in flight
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = rnd_wide(); in_tag = TW'(i + 1); in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("mid_busy_before", W2'(busy), W2'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", W2'(out_valid), W2'(0));
    chk("mid_rst_y", W2'(y), W2'(0));
    chk("mid_rst_tag", W2'(out_tag), W2'(0));
    chk("mid_rst_err", W2'(out_err), W2'(0));
    chk("mid_rst_busy", W2'(busy), W2'(0));
    chk("mid_rst_in_ready", W2'(in_ready), W2'(1));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("mid_no_stale", W2'(out_valid), W2'(0));
    end
    load_cfg(N'(13), 4);
    single_op(W2'(200), 4'hA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
